rr_handshake_arbiter: RTL and testbench
=======================================

// Module: rr_handshake_arbiter
// PURPOSE
//  Shares one start/done handshake resource among N_REQ requesters, e.g. a
//  sequencer FSM that waits for start high, then done, then start low.
//  Uses round-robin fairness and a full four-phase handshake on both sides.
//  Sits between the requesting control FSMs and the shared resource.
//  An optional watchdog terminates a transaction if the resource never
//  asserts done.
// PARAMETERS
//  N_REQ    4   number of requesters; legal range 2..16
//  TIMEOUT  64  max cycles in ST_START waiting for res_done; 0 disables
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              asynchronous, active-high; all state cleared
//  req        in   N_REQ          per-requester request, held until ack seen
//  ack        out  N_REQ          one-hot completion acknowledge
//  gnt        out  N_REQ          one-hot grant, high ST_START..ST_ACK
//  gnt_id     out  $clog2(N_REQ)  index of current/last grantee
//  err        out  1              high with ack when transaction timed out
//  res_start  out  1              start to shared resource
//  res_done   in   1              done from shared resource
// BEHAVIOUR
//  - All outputs are registered (FSM state, idx, err flops); no comb path from inputs.
//  - Reset values: ack=0, gnt=0, gnt_id=0, err=0, res_start=0, state=ST_IDLE,
//    ptr=0, wd_cnt=0. Reset mid-transaction drops res_start immediately.
//    No resumption after reset.
//  - ST_IDLE: if |req at edge k, winner = first set bit scanning ptr, ptr+1, ...
//    (mod N_REQ). idx<=winner, goto ST_START. gnt[idx] and res_start are high
//    from edge k, i.e. 1 cycle of latency.
//  - ST_START: res_start=1, gnt[idx]=1, wd_cnt increments each cycle.
//    * res_done=1 -> ST_ACK, err<=0.
//    * else if TIMEOUT!=0 and wd_cnt==TIMEOUT-1 -> ST_ACK, err<=1.
//    * res_done and timeout in the same cycle: done wins, err=0.
//    * Requester dropping req in ST_START is ignored; the transaction completes.
//  - ST_ACK: res_start=0, ack[idx]=1, gnt[idx]=1, err held.
//    * Exit to ST_IDLE when res_done==0 AND req[idx]==0.
//    * On exit: ack, gnt, err clear; ptr <= (idx+1) mod N_REQ; wd_cnt <= 0.
//  - gnt_id = idx at all times, including in ST_IDLE (last grantee).
//  - Arithmetic: ptr and idx are $clog2(N_REQ) bits. Wrap to 0 is explicit when
//    N_REQ is not a power of two.
//    wd_cnt is $clog2(TIMEOUT+1) bits and saturates, never wraps.
//  - Non-grantee reqs are ignored until ST_IDLE. Min turnaround between grants
//    is 1 ST_IDLE cycle. Back-to-back transactions by the same requester are
//    allowed when it is the only requester.
//  - Fairness: a continuously requesting line is granted within N_REQ
//    transactions.
//  - Unreachable state encodings -> ST_IDLE with outputs deasserted.
// STRUCTURE
//  - arb_pkg:
//    * typedef enum logic [1:0] {ST_IDLE, ST_START, ST_ACK} arb_state_t
//    * localparam MAX_REQ=16
//  - Sub-module rr_picker (combinational): inputs req, ptr; outputs valid and
//    winner index. It is a rotate, priority-encode, un-rotate chain and is
//    reusable by other arbiters.
//  - Top: state register, idx/ptr/err registers, wd_cnt counter, output decode.
// TESTING
//  1. Reset asserted mid-ST_START (req=0001, res_start=1) -> next edge all
//     outputs 0, ptr=0; after release, req=0010 -> gnt=0010.
//  2. Single req=0100 held, res_done high 3 cycles later -> gnt=0100 and
//     res_start at edge+1; ack=0100, err=0. Drop req and res_done ->
//     ST_IDLE, ptr=3.
//  3. req=1111 held, resource answers each start -> grant order 0,1,2,3,0.
//     Each ack is followed by 1 idle cycle.
//  4. TIMEOUT=4, req=0001, res_done stuck 0 -> res_start high exactly 4
//     cycles, then ack=0001 with err=1. req low -> ST_IDLE, err=0.
//  5. res_done rises on cycle TIMEOUT-1 -> ack with err=0. In ST_ACK, with
//     req[idx]=0 but res_done still 1, the FSM stays in ST_ACK until
//     res_done=0.
//  6. N_REQ=3, ptr=2, req=011 -> winner 0 (wrap); grantee drops req during
//     ST_START -> transaction still completes with ack.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and limits for the round-robin handshake arbiter family.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_t;

    localparam int MAX_REQ = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Rotates the request vector so that ptr sits at bit 0, takes the lowest set
// bit, then adds ptr back (mod N) to recover the absolute winner index.
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] winner
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [W-1:0]   offset;
    logic [W:0]     sum;

    assign doubled = {req, req};
    assign rotated = doubled[ptr +: N];
    assign valid   = |req;

    // Priority-encode the rotated vector: lowest set bit is closest to ptr.
    always_comb begin
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = W'(i);
            end
        end
    end

    // Un-rotate with an explicit wrap so non-power-of-two N stays in range.
    always_comb begin
        sum = {1'b0, offset} + {1'b0, ptr};
        if (sum >= (W + 1)'(N)) begin
            sum = sum - (W + 1)'(N);
        end
        winner = sum[W-1:0];
    end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter sharing one start/done resource between N_REQ
// requesters, four-phase handshake on both sides, optional done watchdog.
module rr_handshake_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     err,
    output logic                     res_start,
    input  logic                     res_done
);

    localparam int IDW = $clog2(N_REQ);
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_START = ST_START;
    localparam logic [1:0] S_ACK   = ST_ACK;

    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
    localparam logic [WDW-1:0] WD_MAX  = '1;

    logic [1:0]       state;
    logic [IDW-1:0]   idx;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   idx_next;
    logic [WDW-1:0]   wd_cnt;
    logic [N_REQ-1:0] grant_oh;
    logic             pick_valid;
    logic [IDW-1:0]   pick_winner;

    rr_picker #(
        .N (N_REQ),
        .W (IDW)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign idx_next = (idx == IDW'(N_REQ - 1)) ? '0 : idx + IDW'(1);
    assign grant_oh = N_REQ'(1) << idx;
    assign gnt_id   = idx;

    // Handshake FSM: pick a winner, hold start until done or watchdog, then
    // hold ack until both the resource and the grantee have released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            ptr    <= '0;
            err    <= 1'b0;
            wd_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        idx   <= pick_winner;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (wd_cnt != WD_MAX) begin
                        wd_cnt <= wd_cnt + WDW'(1);
                    end
                    if (res_done) begin
                        state <= S_ACK;
                        err   <= 1'b0;
                    end else if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
                        state <= S_ACK;
                        err   <= 1'b1;
                    end
                end
                S_ACK: begin
                    if (!res_done && !req[idx]) begin
                        state  <= S_IDLE;
                        err    <= 1'b0;
                        wd_cnt <= '0;
                        ptr    <= idx_next;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    err    <= 1'b0;
                    wd_cnt <= '0;
                end
            endcase
        end
    end

    // Output decode from registered state and index only.
    always_comb begin
        gnt       = '0;
        ack       = '0;
        res_start = 1'b0;
        case (state)
            S_START: begin
                gnt       = grant_oh;
                res_start = 1'b1;
            end
            S_ACK: begin
                gnt = grant_oh;
                ack = grant_oh;
            end
            default: begin
                gnt       = '0;
                ack       = '0;
                res_start = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Self-checking bench for rr_handshake_arbiter: a 4-requester instance with a
// short watchdog and a 3-requester instance for the non-power-of-two wrap.
module tb_rr_handshake_arbiter;

    typedef struct {
        int   id;
        logic err;
    } ackExp_t;

    logic       clk;
    logic       reset;

    logic [3:0] reqA;
    logic [3:0] ackA;
    logic [3:0] gntA;
    logic [1:0] gnt_idA;
    logic       errA;
    logic       res_startA;
    logic       res_doneA;

    logic [2:0] reqB;
    logic [2:0] ackB;
    logic [2:0] gntB;
    logic [1:0] gnt_idB;
    logic       errB;
    logic       res_startB;
    logic       res_doneB;

    int checks;
    int errors;

    int      gqA[$];
    int      gqB[$];
    ackExp_t aqA[$];
    ackExp_t aqB[$];

    logic [3:0] prevGntA;
    logic [3:0] prevAckA;
    logic [2:0] prevGntB;
    logic [2:0] prevAckB;

    rr_handshake_arbiter #(
        .N_REQ   (4),
        .TIMEOUT (4)
    ) dutA (
        .clk       (clk),
        .reset     (reset),
        .req       (reqA),
        .ack       (ackA),
        .gnt       (gntA),
        .gnt_id    (gnt_idA),
        .err       (errA),
        .res_start (res_startA),
        .res_done  (res_doneA)
    );

    rr_handshake_arbiter #(
        .N_REQ   (3),
        .TIMEOUT (4)
    ) dutB (
        .clk       (clk),
        .reset     (reset),
        .req       (reqB),
        .ack       (ackB),
        .gnt       (gntB),
        .gnt_id    (gnt_idB),
        .err       (errB),
        .res_start (res_startB),
        .res_done  (res_doneB)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge, well away from the sampling edge.
    task automatic applyStimulus(input logic [3:0] r, input logic d);
        @(negedge clk);
        reqA      = r;
        res_doneA = d;
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return res_startA;
            1:       return |ackA;
            2:       return res_startB;
            default: return |ackB;
        endcase
    endfunction

    // Bounded wait for a DUT event; an expired budget is reported as a failure.
    task automatic waitFor(input int sel, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!probe(sel) && n < 20);
        if (!probe(sel)) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s wait expired actual=0 expected=1", name);
        end
    endtask

    // Scoreboard monitor: every new grant or ack pops the next expectation.
    always @(negedge clk) begin : monitor
        int      e;
        ackExp_t a;
        if (gntA != 4'b0 && prevGntA == 4'b0) begin
            if (gqA.size() == 0) begin
                checkOutput("A_grant_unexpected", int'(gntA), 0);
            end else begin
                e = gqA.pop_front();
                checkOutput("A_gnt", int'(gntA), 1 << e);
                checkOutput("A_gnt_id", int'(gnt_idA), e);
                checkOutput("A_res_start", int'(res_startA), 1);
            end
        end
        if (ackA != 4'b0 && prevAckA == 4'b0) begin
            if (aqA.size() == 0) begin
                checkOutput("A_ack_unexpected", int'(ackA), 0);
            end else begin
                a = aqA.pop_front();
                checkOutput("A_ack", int'(ackA), 1 << a.id);
                checkOutput("A_err", int'(errA), int'(a.err));
            end
        end
        if (gntB != 3'b0 && prevGntB == 3'b0) begin
            if (gqB.size() == 0) begin
                checkOutput("B_grant_unexpected", int'(gntB), 0);
            end else begin
                e = gqB.pop_front();
                checkOutput("B_gnt", int'(gntB), 1 << e);
                checkOutput("B_gnt_id", int'(gnt_idB), e);
            end
        end
        if (ackB != 3'b0 && prevAckB == 3'b0) begin
            if (aqB.size() == 0) begin
                checkOutput("B_ack_unexpected", int'(ackB), 0);
            end else begin
                a = aqB.pop_front();
                checkOutput("B_ack", int'(ackB), 1 << a.id);
                checkOutput("B_err", int'(errB), int'(a.err));
            end
        end
        prevGntA = gntA;
        prevAckA = ackA;
        prevGntB = gntB;
        prevAckB = ackB;
    end

    // Hard stop in case the run wanders off.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL global_watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        int seq[5];
        int cnt;
        checks    = 0;
        errors    = 0;
        prevGntA  = '0;
        prevAckA  = '0;
        prevGntB  = '0;
        prevAckB  = '0;
        reset     = 1'b1;
        reqA      = '0;
        res_doneA = 1'b0;
        reqB      = '0;
        res_doneB = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_gnt", int'(gntA), 0);
        checkOutput("rst_ack", int'(ackA), 0);
        checkOutput("rst_err", int'(errA), 0);
        checkOutput("rst_res_start", int'(res_startA), 0);
        checkOutput("rst_gnt_id", int'(gnt_idA), 0);
        checkOutput("rst_B_gnt", int'(gntB), 0);
        reset = 1'b0;

        $display("[TB] reset in the middle of a start phase");
        gqA.push_back(0);
        applyStimulus(4'b0001, 1'b0);
        waitFor(0, "t1_start");
        #2 reset = 1'b1;
        #1;
        checkOutput("t1_rst_gnt", int'(gntA), 0);
        checkOutput("t1_rst_res_start", int'(res_startA), 0);
        checkOutput("t1_rst_ack", int'(ackA), 0);
        checkOutput("t1_rst_gnt_id", int'(gnt_idA), 0);
        @(negedge clk);
        reqA = '0;
        @(negedge clk);
        reset = 1'b0;
        gqA.push_back(1);
        aqA.push_back('{id: 1, err: 1'b0});
        applyStimulus(4'b0010, 1'b0);
        waitFor(0, "t1b_start");
        res_doneA = 1'b1;
        waitFor(1, "t1b_ack");
        reqA      = '0;
        res_doneA = 1'b0;
        @(negedge clk);
        checkOutput("t1b_idle_gnt", int'(gntA), 0);

        $display("[TB] single requester with delayed done");
        gqA.push_back(2);
        aqA.push_back('{id: 2, err: 1'b0});
        applyStimulus(4'b0100, 1'b0);
        waitFor(0, "t2_start");
        repeat (2) @(negedge clk);
        res_doneA = 1'b1;
        waitFor(1, "t2_ack");
        reqA      = '0;
        res_doneA = 1'b0;
        @(negedge clk);
        checkOutput("t2_idle_gnt", int'(gntA), 0);
        checkOutput("t2_last_id", int'(gnt_idA), 2);

        $display("[TB] all four requesting, rotation from ptr=3");
        seq = '{3, 0, 1, 2, 3};
        foreach (seq[i]) begin
            gqA.push_back(seq[i]);
            aqA.push_back('{id: seq[i], err: 1'b0});
        end
        applyStimulus(4'b1111, 1'b0);
        waitFor(0, "t3_start");
        for (int i = 0; i < 5; i++) begin
            res_doneA = 1'b1;
            waitFor(1, "t3_ack");
            res_doneA     = 1'b0;
            reqA[seq[i]]  = 1'b0;
            @(negedge clk);
            checkOutput("t3_idle_gap", int'(gntA), 0);
            if (i < 4) begin
                reqA[seq[i]] = 1'b1;
                @(negedge clk);
                checkOutput("t3_turnaround", int'(res_startA), 1);
            end else begin
                reqA = '0;
            end
        end

        $display("[TB] watchdog expiry with done stuck low");
        gqA.push_back(0);
        aqA.push_back('{id: 0, err: 1'b1});
        applyStimulus(4'b0001, 1'b0);
        waitFor(0, "t4_start");
        cnt = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (res_startA) cnt++;
            else break;
        end
        checkOutput("t4_start_len", cnt, 4);
        checkOutput("t4_err", int'(errA), 1);
        reqA = '0;
        @(negedge clk);
        checkOutput("t4_err_clear", int'(errA), 0);
        checkOutput("t4_idle_gnt", int'(gntA), 0);

        $display("[TB] done on the last watchdog cycle, done held in ack");
        gqA.push_back(0);
        aqA.push_back('{id: 0, err: 1'b0});
        applyStimulus(4'b0001, 1'b0);
        waitFor(0, "t5_start");
        repeat (3) @(negedge clk);
        res_doneA = 1'b1;
        waitFor(1, "t5_ack");
        reqA = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("t5_hold_ack", int'(ackA), 1);
        end
        res_doneA = 1'b0;
        @(negedge clk);
        checkOutput("t5_idle_ack", int'(ackA), 0);
        checkOutput("t5_idle_gnt", int'(gntA), 0);

        $display("[TB] three requesters, wrap and dropped request");
        gqB.push_back(1);
        aqB.push_back('{id: 1, err: 1'b0});
        @(negedge clk);
        reqB = 3'b010;
        waitFor(2, "t6a_start");
        res_doneB = 1'b1;
        waitFor(3, "t6a_ack");
        res_doneB = 1'b0;
        reqB      = '0;
        @(negedge clk);
        gqB.push_back(0);
        aqB.push_back('{id: 0, err: 1'b0});
        reqB = 3'b011;
        waitFor(2, "t6b_start");
        reqB = '0;
        @(negedge clk);
        checkOutput("t6_hold_start", int'(res_startB), 1);
        res_doneB = 1'b1;
        waitFor(3, "t6b_ack");
        res_doneB = 1'b0;
        @(negedge clk);
        checkOutput("t6_idle_gnt", int'(gntB), 0);
        checkOutput("t6_last_id", int'(gnt_idB), 0);

        repeat (3) @(negedge clk);
        checkOutput("A_grants_pending", gqA.size(), 0);
        checkOutput("A_acks_pending", aqA.size(), 0);
        checkOutput("B_grants_pending", gqB.size(), 0);
        checkOutput("B_acks_pending", aqB.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
